// File: rtl/gshare_predictor.sv
//-----------------------------------------------------------------------------
// gshare_predictor
//
// Prediction side of a gshare branch predictor built from 2-bit saturating
// counters. The pattern history table (PHT) holds 2^HIST_W counters indexed
// by pc XOR global history register (GHR). Predictions are combinational from
// the current state. Training updates from the resolve stage move one counter
// and restore the GHR when a branch was mispredicted.
//
// Optional feature (compile-time macro GSHARE_PREDICT_FWD_EN):
//   When defined, a prediction that hits the same PHT entry being trained in
//   the same cycle sees the post-training counter value. The PHT write is the
//   same either way.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   areset              synchronous active-high reset
//   predict_valid       prediction request this cycle
//   predict_pc          pc index of the branch being predicted
//   predict_taken       predicted direction (combinational)
//   predict_history     GHR value used for this prediction (combinational)
//   train_valid         training update this cycle
//   train_taken         resolved outcome
//   train_mispredicted  resolved branch was mispredicted (GHR recovery)
//   train_pc            pc index of the resolved branch
//   train_history       predict_history returned when the branch was predicted
//   ghr                 current GHR, for debug and checking
//-----------------------------------------------------------------------------
module gshare_predictor #(
   parameter int HIST_W = 7
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              predict_valid,
   input  logic [HIST_W-1:0] predict_pc,
   output logic              predict_taken,
   output logic [HIST_W-1:0] predict_history,
   input  logic              train_valid,
   input  logic              train_taken,
   input  logic              train_mispredicted,
   input  logic [HIST_W-1:0] train_pc,
   input  logic [HIST_W-1:0] train_history,
   output logic [HIST_W-1:0] ghr
);

   localparam int ENTRIES = 1 << HIST_W;

   // Saturating 2-bit counter step: up on taken, down on not-taken.
   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

   logic [1:0]        pht_r [ENTRIES];
   logic [HIST_W-1:0] ghr_r;

   logic [HIST_W-1:0] p_idx_s;
   logic [HIST_W-1:0] t_idx_s;
   logic [1:0]        train_next_s;
   logic              pred_taken_s;
   logic [HIST_W-1:0] ghr_next_s;

   assign p_idx_s      = predict_pc ^ ghr_r;
   assign t_idx_s      = train_pc ^ train_history;
   assign train_next_s = sat_step(pht_r[t_idx_s], train_taken);

   // Prediction bit, optionally forwarded from the same-cycle training result.
   always_comb begin
      pred_taken_s = pht_r[p_idx_s][1];
`ifdef GSHARE_PREDICT_FWD_EN
      if (predict_valid && train_valid && (p_idx_s == t_idx_s)) begin
         pred_taken_s = train_next_s[1];
      end else begin
         pred_taken_s = pht_r[p_idx_s][1];
      end
`endif
   end

   // GHR next value: mispredict recovery beats the speculative shift.
   always_comb begin
      ghr_next_s = ghr_r;
      if (train_valid && train_mispredicted) begin
         ghr_next_s = {train_history[HIST_W-2:0], train_taken};
      end else if (predict_valid) begin
         ghr_next_s = {ghr_r[HIST_W-2:0], pred_taken_s};
      end else begin
         ghr_next_s = ghr_r;
      end
   end

   // State update: reset wins over any same-cycle predict or train.
   always_ff @(posedge clk) begin
      if (areset) begin
         ghr_r <= {HIST_W{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            pht_r[i[HIST_W-1:0]] <= 2'b01;
         end
      end else begin
         ghr_r <= ghr_next_s;
         if (train_valid) begin
            pht_r[t_idx_s] <= train_next_s;
         end
      end
   end

   assign predict_taken   = pred_taken_s;
   assign predict_history = ghr_r;
   assign ghr             = ghr_r;

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

   logic       clk = 1'b0;
   logic       areset = 1'b0;
   logic       predict_valid = 1'b0;
   logic [6:0] predict_pc = 7'h00;
   logic       predict_taken;
   logic [6:0] predict_history;
   logic       train_valid = 1'b0;
   logic       train_taken = 1'b0;
   logic       train_mispredicted = 1'b0;
   logic [6:0] train_pc = 7'h00;
   logic [6:0] train_history = 7'h00;
   logic [6:0] ghr;

   gshare_predictor #(.HIST_W(7)) dut (
      .clk(clk), .areset(areset),
      .predict_valid(predict_valid), .predict_pc(predict_pc),
      .predict_taken(predict_taken), .predict_history(predict_history),
      .train_valid(train_valid), .train_taken(train_taken),
      .train_mispredicted(train_mispredicted), .train_pc(train_pc),
      .train_history(train_history), .ghr(ghr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Behavioural model: counter values as plain integers 0..3, history as int.
   int m_pht [128];
   int m_ghr = 0;
   bit model_known = 0;

   // DUT outputs captured during the last drive call
   logic       last_pt;
   logic [6:0] last_ph;

`ifdef GSHARE_PREDICT_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, compare against the model, advance the model.
   task automatic drive(input bit rst, input bit pv, input int ppc,
                        input bit tv, input bit tt, input bit tm,
                        input int tpc, input int th);
      int p, t, nv;
      bit pred;
      @(negedge clk);
      areset = rst;
      predict_valid = pv;
      predict_pc = 7'(ppc);
      train_valid = tv;
      train_taken = tt;
      train_mispredicted = tm;
      train_pc = 7'(tpc);
      train_history = 7'(th);
      #1;
      last_pt = predict_taken;
      last_ph = predict_history;
      p = (ppc ^ m_ghr) & 127;
      t = (tpc ^ th) & 127;
      pred = (m_pht[p] >= 2);
      nv = tt ? ((m_pht[t] == 3) ? 3 : m_pht[t] + 1)
              : ((m_pht[t] == 0) ? 0 : m_pht[t] - 1);
      if (FWD && pv && tv && (p == t)) pred = (nv >= 2);
      if (model_known) begin
         check("model_predict_taken", int'(predict_taken), int'(pred));
         check("model_predict_history", int'(predict_history), m_ghr);
         check("model_ghr", int'(ghr), m_ghr);
      end
      if (rst) begin
         foreach (m_pht[i]) m_pht[i] = 1;
         m_ghr = 0;
         model_known = 1;
      end else begin
         if (tv) m_pht[t] = nv;
         if (tv && tm) m_ghr = ((th << 1) | int'(tt)) & 127;
         else if (pv) m_ghr = ((m_ghr << 1) | int'(pred)) & 127;
      end
      @(posedge clk);
   endtask

   task automatic idle_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // 1: reset, then a prediction at pc 0x05
      idle_reset();
      #1 check("reset_ghr", int'(ghr), 0);
      drive(0, 1, 'h05, 0, 0, 0, 0, 0);
      check("t1_predict_taken", int'(last_pt), 0);
      check("t1_predict_history", int'(last_ph), 0);
      #1 check("t1_ghr_after", int'(ghr), 0);

      // 2: saturating increments and a decrement at entry 0x05
      drive(0, 0, 0, 1, 1, 0, 'h05, 'h00);
      drive(0, 0, 0, 1, 1, 0, 'h05, 'h00);
      drive(0, 1, 'h05, 0, 0, 0, 0, 0);
      check("t2_taken_after_two", int'(last_pt), 1);
      #1 check("t2_ghr", int'(ghr), 'h01);
      drive(0, 0, 0, 1, 1, 0, 'h05, 'h00);
      drive(0, 0, 0, 1, 0, 0, 'h05, 'h00);
      drive(0, 1, 'h05 ^ 'h01, 0, 0, 0, 0, 0);
      check("t2_taken_weak", int'(last_pt), 1);

      // 3: speculative shifts 1,0,1 then recovery with a concurrent predict
      idle_reset();
      drive(0, 0, 0, 1, 1, 0, 'h10, 'h00);
      drive(0, 0, 0, 1, 1, 0, 'h10, 'h00);
      drive(0, 1, 'h10, 0, 0, 0, 0, 0);
      check("t3_pred0", int'(last_pt), 1);
      drive(0, 1, 'h20, 0, 0, 0, 0, 0);
      check("t3_pred1", int'(last_pt), 0);
      drive(0, 1, 'h12, 0, 0, 0, 0, 0);
      check("t3_pred2", int'(last_pt), 1);
      #1 check("t3_ghr_spec", int'(ghr), 'h05);
      drive(0, 1, 'h33, 1, 1, 1, 'h00, 'h02);
      #1 check("t3_ghr_recover", int'(ghr), 'h05);

      // 4: recovery beats a same-cycle prediction
      drive(0, 1, 'h01, 1, 0, 1, 'h00, 'h7F);
      #1 check("t4_ghr", int'(ghr), 'h7E);

      // 5: same-cycle predict and train on one entry
      idle_reset();
      drive(0, 1, 'h05, 1, 1, 0, 'h05, 'h00);
      check("t5_same_idx", int'(last_pt), int'(FWD));
      drive(0, 0, 'h05 ^ int'(FWD), 0, 0, 0, 0, 0);
      check("t5_next_read", int'(last_pt), 1);

      // 6: reset in the middle of training
      idle_reset();
      drive(0, 0, 0, 1, 1, 0, 'h10, 'h00);
      drive(0, 0, 0, 1, 1, 0, 'h10, 'h00);
      drive(0, 0, 0, 1, 1, 1, 'h00, 'h19);
      #1 check("t6_ghr_set", int'(ghr), 'h33);
      drive(1, 1, 'h10, 1, 0, 0, 'h10, 'h00);
      #1 check("t6_ghr_reset", int'(ghr), 0);
      drive(0, 1, 'h10, 0, 0, 0, 0, 0);
      check("t6_pred_reset", int'(last_pt), 0);

      // Randomised traffic checked against the model every cycle
      for (int n = 0; n < 4000; n++) begin
         bit rst, pv, tv, tt, tm;
         int ppc, tpc, th;
         rst = ($urandom_range(0, 299) == 0);
         pv  = ($urandom_range(0, 3) != 0);
         tv  = ($urandom_range(0, 2) != 0);
         tt  = $urandom_range(0, 1);
         tm  = ($urandom_range(0, 4) == 0);
         ppc = $urandom_range(0, 15);
         th  = $urandom_range(0, 127);
         // Keep indices clustered so counters saturate and collisions occur
         if ($urandom_range(0, 2) == 0) tpc = (ppc ^ m_ghr ^ th) & 127;
         else tpc = ($urandom_range(0, 15) ^ th) & 127;
         drive(rst, pv, ppc, tv, tt, tm, tpc, th);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Prediction side of the 2-bit saturating branch counter scheme.
- Holds a pattern history table (PHT) of 2^HIST_W two-bit counters, indexed by pc XOR global history register (GHR).
- Returns a taken/not-taken prediction plus the history snapshot it used.
- Accepts training updates from the resolve stage, which trains counters and recovers the GHR on mispredict.

Parameters:
HIST_W, 7, width of the GHR, of the pc index and of the PHT index; the PHT has 2^HIST_W entries.

Ports:
clk  input  1  clock; all state updates on the rising edge
areset  input  1  reset; synchronous, active-high
predict_valid  input  1  prediction request this cycle
predict_pc  input  HIST_W  pc index of the branch being predicted
predict_taken  output  1  prediction; combinational from current state
predict_history  output  HIST_W  GHR value used to form this prediction; combinational
train_valid  input  1  training update this cycle
train_taken  input  1  resolved outcome
train_mispredicted  input  1  the resolved branch was mispredicted
train_pc  input  HIST_W  pc index of the resolved branch
train_history  input  HIST_W  predict_history returned when that branch was predicted
ghr  output  HIST_W  current GHR, for debug and checking

Behaviour:
- Reset (areset high at a clk edge): GHR <= 0; every PHT entry <= 2'b01 (weakly not-taken). Outputs follow state combinationally, so predict_taken=0 and predict_history=0 in the cycle after reset.
- Prediction, zero latency:
  - p_idx = predict_pc ^ GHR.
  - predict_taken = PHT[p_idx][1].
  - predict_history = GHR.
  - Outputs are valid whenever predict_valid=1; they are don't-care otherwise but still driven from state.
- PHT training, on a clk edge with train_valid=1:
  - t_idx = train_pc ^ train_history.
  - train_taken=1: increment, saturating at 3.
  - train_taken=0: decrement, saturating at 0.
  - No other entry changes. train_mispredicted does not affect the PHT update.
- GHR update, on a clk edge, priority order:
  1. train_valid & train_mispredicted: GHR <= {train_history[HIST_W-2:0], train_taken}. Recovery overrides any same-cycle prediction.
  2. Else predict_valid: GHR <= {GHR[HIST_W-2:0], predict_taken}. The speculative shift uses the predicted outcome.
  3. Else: GHR holds.
- train_valid with train_mispredicted=0 never changes the GHR.
- Simultaneous predict and train to the same index (p_idx == t_idx): prediction reads the pre-update counter. The update becomes visible the next cycle (see Optional Feature).
- areset has priority over all activity. Predict or train in the reset cycle is discarded.
- Implementation: no X on outputs; no internal state besides the PHT and GHR.

Optional Feature:
- Macro: GSHARE_PREDICT_FWD_EN.
- Defined: when predict_valid & train_valid & (p_idx == t_idx) in the same cycle, predict_taken is bit 1 of the post-training counter value (the saturated increment/decrement result). The speculative GHR shift uses this forwarded prediction.
- Undefined: predict_taken reads the stored counter, per Behaviour.
- The PHT write itself is identical either way.

Test Plan:
1. Reset, then predict_valid=1, predict_pc=0x05 -> predict_taken=0, predict_history=0x00. After the edge, ghr=0x00 (shifted in 0).
2. Train pc=0x05, history=0x00, taken=1, mispredicted=0, twice -> entry 0x05 goes 01->10->11. Predict pc=0x05 with ghr=0 -> predict_taken=1. A third taken train keeps the entry at 3, and one not-taken train then yields predict_taken=1 (2'b10).
3. From ghr=0x00, predict_valid for 3 cycles with predicted outcomes 1,0,1 -> ghr=0x05. Then train_valid=1, mispredicted=1, train_history=0x02, taken=1 -> ghr=0x05 next cycle, regardless of predict_valid in that cycle.
4. Same cycle: predict_valid=1 and train_valid=1, mispredicted=1, train_history=0x7F, taken=0 -> ghr=0x7E. The predictive shift is ignored.
5. Same cycle, same index (entry=01, train taken): without GSHARE_PREDICT_FWD_EN, predict_taken=0. With it, predict_taken=1. In both cases the next-cycle read of that entry gives 1.
6. Assert areset mid-training after entry 0x10 reaches 3 and ghr=0x33 -> next cycle ghr=0x00 and predict pc=0x10 gives predict_taken=0.
